// File: rtl/seg7_pkg.sv
// Shared constants for the Basys-2 seven-segment driver: active-low glyphs
// ({g,f,e,d,c,b,a}), the blank character code and the drive/blank phase encoding.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK   = 7'h7F;
  localparam logic [6:0] SEG_DASH    = 7'h3F;
  localparam logic [6:0] SEG_UNKNOWN = 7'b0110110;
  localparam logic [7:0] ASCII_BLANK = 8'hFF;

  typedef enum logic {
    PH_DRIVE = 1'b0,
    PH_BLANK = 1'b1
  } phase_t;

  // Hex glyphs, lower case for b and d so they cannot be confused with 8 and 0.
  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_ascii_decoder.sv
// Combinational ASCII byte to active-low {SEG, DP}; `blank` flags the 8'hFF
// "nothing here" code so the caller can keep that digit's anode dark.
module seg7_ascii_decoder
  import seg7_pkg::*;
(
  input  logic [7:0] code,
  output logic [6:0] seg,
  output logic       dp,
  output logic       blank
);

  logic [6:0] ch;
  assign ch = code[6:0];

  always_comb begin
    seg   = SEG_UNKNOWN;
    dp    = ~code[7];
    blank = 1'b0;
    if (code == ASCII_BLANK) begin
      seg   = SEG_BLANK;
      dp    = 1'b1;
      blank = 1'b1;
    end else if (ch >= 7'h30 && ch <= 7'h39) begin
      seg = hex_glyph(ch[3:0]);
    end else if ((ch >= 7'h41 && ch <= 7'h46) || (ch >= 7'h61 && ch <= 7'h66)) begin
      // 'A'/'a' have low nibble 1, so +9 lands on hex value 10
      seg = hex_glyph(4'(ch[3:0] + 4'd9));
    end else if (ch == 7'h20) begin
      seg = SEG_BLANK;
    end else if (ch == 7'h2D) begin
      seg = SEG_DASH;
    end
  end

endmodule

// File: rtl/seg7_display_driver.sv
// Four-digit multiplexed 7-segment driver with per-frame character snapshot and
// anti-ghosting blank interval. Optional dimming is enabled by defining SEG7_DIM_EN.
module seg7_display_driver
  import seg7_pkg::*;
#(
  parameter int CYCLES_PER_DIGIT = 50000,
  parameter int BLANK_CYCLES     = 500
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] asciiOne,
  input  logic [7:0] asciiTwo,
  input  logic [7:0] asciiThree,
  input  logic [7:0] asciiFour,
`ifdef SEG7_DIM_EN
  input  logic [3:0] BRIGHT,
`endif
  output logic [6:0] SEG,
  output logic       DP,
  output logic [3:0] AN
);

  localparam int CW = $clog2(CYCLES_PER_DIGIT);
  localparam logic [CW-1:0] CNT_MAX   = CW'(CYCLES_PER_DIGIT - 1);
  localparam logic [CW-1:0] DRIVE_END = CW'(CYCLES_PER_DIGIT - BLANK_CYCLES);

  logic [CW-1:0] cnt;
  logic [1:0]    slot;
  logic [7:0]    shadow [4];
  logic          frame_end;
  phase_t        phase;
  logic [6:0]    dec_seg;
  logic          dec_dp;
  logic          dec_blank;
  logic          pwm_ok;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;

  assign frame_end = (slot == 2'd3) && (cnt == CNT_MAX);
  assign phase     = (cnt < DRIVE_END) ? PH_DRIVE : PH_BLANK;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt  <= '0;
      slot <= 2'd0;
    end else if (cnt == CNT_MAX) begin
      cnt  <= '0;
      slot <= slot + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Snapshot all four characters at once so a scroll step cannot tear a frame.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 4; i++) shadow[i] <= ASCII_BLANK;
    end else if (frame_end) begin
      shadow[0] <= asciiOne;
      shadow[1] <= asciiTwo;
      shadow[2] <= asciiThree;
      shadow[3] <= asciiFour;
    end
  end

`ifdef SEG7_DIM_EN
  logic [3:0] pwm;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) pwm <= 4'd0;
    else       pwm <= pwm + 4'd1;
  end

  assign pwm_ok = (pwm <= BRIGHT);
`else
  assign pwm_ok = 1'b1;
`endif

  seg7_ascii_decoder u_decoder (
    .code  (shadow[slot]),
    .seg   (dec_seg),
    .dp    (dec_dp),
    .blank (dec_blank)
  );

  always_comb begin
    an_next  = 4'b1111;
    seg_next = SEG_BLANK;
    dp_next  = 1'b1;
    if (phase == PH_DRIVE) begin
      seg_next = dec_seg;
      dp_next  = dec_dp;
      if (!dec_blank && pwm_ok) an_next = ~(4'b1000 >> slot);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      AN  <= 4'b1111;
      SEG <= SEG_BLANK;
      DP  <= 1'b1;
    end else begin
      AN  <= an_next;
      SEG <= seg_next;
      DP  <= dp_next;
    end
  end

endmodule

// File: doc/seg7_display_driver.md
# seg7_display_driver

Consumes the four ASCII character bytes produced by the scrolling character source and drives the Basys-2 four-digit common-anode 7-segment display. Time-multiplexes the digits with a programmable per-digit slot and an anti-ghosting blank interval. Snapshots all four characters once per frame so a scroll step never tears mid-frame. Sits between the character source and the board pins.

## Interface
- CYCLES_PER_DIGIT, 50000: clock cycles per digit slot (1 kHz per digit at 50 MHz); must be at least 2.
- BLANK_CYCLES, 500: cycles at the end of each slot with all anodes off; must satisfy 1 ≤ BLANK_CYCLES < CYCLES_PER_DIGIT.
- CLK  in  1  system clock; all logic is on the rising edge.
- RESET  in  1  asynchronous, active-high.
- asciiOne  in  8  leftmost character (AN[3]).
- asciiTwo  in  8  second character (AN[2]).
- asciiThree  in  8  third character (AN[1]).
- asciiFour  in  8  rightmost character (AN[0]).
- BRIGHT  in  4  dimming level; present only with SEG7_DIM_EN.
- SEG  out  7  {g,f,e,d,c,b,a}, active-low.
- DP  out  1  decimal point, active-low.
- AN  out  4  digit anodes, active-low, one-hot-low or all high.

## Operation
- Slot counter cnt runs 0..CYCLES_PER_DIGIT-1. Digit index slot runs 0..3 and advances when cnt wraps. Slot 3 wraps to slot 0; one such wrap is one frame.
- Phase: DRIVE while cnt < CYCLES_PER_DIGIT-BLANK_CYCLES, otherwise BLANK. BLANK forces AN=4'b1111, SEG=7'h7F, DP=1.
- Slot mapping: slot 0 shows shadow0 on AN[3], slot 1 on AN[2], slot 2 on AN[1], slot 3 on AN[0].
- Shadow registers shadow0..3 load asciiOne..asciiFour on the edge where slot==3 and cnt==CYCLES_PER_DIGIT-1. Input changes at any other time are ignored until the next frame.
- Decode applies to the shadowed byte b:
  - b==8'hFF: blank, DP off.
  - Otherwise b[7] drives DP on, and b[6:0] is decoded as follows.
  - '0'-'9': standard glyphs.
  - 'A'-'F' and 'a'-'f': A b C d E F glyphs.
  - ' ': blank.
  - '-': g only.
  - Any other code: a+d+g (7'b0110110).
- All outputs are registered. No combinational path runs from the inputs to the pins.

## Timing
- Reset values: AN=4'b1111, SEG=7'h7F, DP=1, cnt=0, slot=0, shadow0..3=8'hFF.
- The first frame after reset is therefore blank. Characters first appear in slot 0 of the second frame.
- Outputs lag the counter state by one cycle. The pins for state (slot, cnt) appear on the edge after that state is current.
- RESET asserted mid-slot forces all outputs to their reset values immediately (asynchronously). Counting restarts at slot 0, cnt 0 on the first edge after release.
- At every slot boundary the anodes have been high for exactly BLANK_CYCLES cycles before the next anode goes low. Two anodes are never low in the same cycle.
- Frame period is 4*CYCLES_PER_DIGIT cycles.

## Configuration
- SEG7_DIM_EN defined:
  - Adds the BRIGHT port and a free-running 4-bit counter pwm (reset 0, +1 every cycle).
  - During DRIVE, the anode is low only while pwm ≤ BRIGHT, giving (BRIGHT+1)/16 duty. BRIGHT=15 equals full drive.
  - SEG and DP hold the digit's values for the whole DRIVE phase.
  - BRIGHT is sampled every cycle and is not shadowed.
- SEG7_DIM_EN undefined: no BRIGHT port, no pwm counter, and the anode is low for the whole DRIVE phase.

## Structure
- Shared package seg7_pkg holds:
  - glyph constants (SEG_BLANK=7'h7F, SEG_DASH, SEG_UNKNOWN, hex digit glyphs);
  - the ASCII_BLANK=8'hFF constant;
  - the phase encoding (PH_DRIVE, PH_BLANK).
- One sub-module, seg7_ascii_decoder: combinational byte-to-{SEG,DP}. The top level registers its output.
- The top level contains the counters, phase logic, shadow registers and output registers.

## Test plan
All scenarios use CYCLES_PER_DIGIT=8 and BLANK_CYCLES=2.
- Reset and first frame: release RESET with inputs "1234" -> AN=1111 for the whole first frame (32 cycles). Second frame: AN=0111 with SEG=digit '1' glyph for 6 cycles, then 1111 for 2 cycles, then 1011 with '2', and so on.
- Frame snapshot: change asciiOne from "1" to "9" mid-frame -> the old glyph persists until the next frame boundary, then slot 0 shows '9'. There is no partial update.
- Decode coverage: sweep '0'-'9', 'A'-'F', 'a'-'f', ' ', '-', 8'hFF, 8'h80|'5', 8'h40 -> the expected glyphs. 8'hB5 shows '5' with DP=0. 8'hFF shows blank with DP=1. 8'h40 shows SEG=7'b0110110.
- Anti-ghosting: monitor every cycle -> AN is never two-low. AN=1111 is held for exactly 2 cycles before every anode transition.
- Reset mid-operation: assert RESET in slot 2, cnt 3 -> outputs go to reset values in the same cycle. After release, the blank first frame repeats.
- SEG7_DIM_EN with BRIGHT=3 -> during DRIVE the anode is low 4 of every 16 pwm counts. BRIGHT=15 -> output is identical to the non-dimmed build.
